// File: rtl/axi_conf.sv
// AXI bundle definitions shared by the slave connector and its terminators.
// Widths, channel structs and response codes.
package axi_conf;

  localparam int ID_WIDTH   = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int USER_WIDTH = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [USER_WIDTH-1:0] user;
  } ax_chan_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            resp;
    logic [USER_WIDTH-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_err_slave.sv
// Terminating AXI slave: swallows every transaction and answers with an
// error response. Independent single-outstanding read and write FSMs.
module axi_err_slave
  import axi_conf::*;
#(
  parameter logic [1:0]  RESP  = axi_conf::RESP_SLVERR,
  parameter logic [63:0] RDATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  axi_req_i,
  output resp_t axi_resp_o
);

  localparam logic [DATA_WIDTH-1:0] RDATA_W = DATA_WIDTH'(RDATA);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  w_state_e            w_state, w_next;
  r_state_e            r_state, r_next;
  logic [ID_WIDTH-1:0] b_id;
  logic [ID_WIDTH-1:0] r_id;
  logic [7:0]          cnt;

  // Most request fields are intentionally ignored.
  logic unused_req;
  assign unused_req = ^axi_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b_id <= '0;
      r_id <= '0;
      cnt  <= '0;
    end else begin
      if (w_state == W_IDLE && axi_req_i.aw_valid)
        b_id <= axi_req_i.aw.id;
      if (r_state == R_IDLE && axi_req_i.ar_valid) begin
        r_id <= axi_req_i.ar.id;
        cnt  <= axi_req_i.ar.len;
      end else if (r_state == R_DATA && axi_req_i.r_ready && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (axi_req_i.aw_valid) w_next = W_DATA;
      W_DATA: if (axi_req_i.w_valid && axi_req_i.w.last) w_next = W_RESP;
      W_RESP: if (axi_req_i.b_ready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (axi_req_i.ar_valid) r_next = R_DATA;
      R_DATA: if (axi_req_i.r_ready && cnt == 8'd0) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = (w_state == W_IDLE);
    axi_resp_o.w_ready  = (w_state == W_DATA);
    axi_resp_o.b_valid  = (w_state == W_RESP);
    axi_resp_o.b.id     = b_id;
    axi_resp_o.b.resp   = RESP;
    axi_resp_o.b.user   = '0;
    axi_resp_o.ar_ready = (r_state == R_IDLE);
    axi_resp_o.r_valid  = (r_state == R_DATA);
    axi_resp_o.r.id     = r_id;
    axi_resp_o.r.data   = RDATA_W;
    axi_resp_o.r.resp   = RESP;
    axi_resp_o.r.last   = (r_state == R_DATA) && (cnt == 8'd0);
    axi_resp_o.r.user   = '0;
  end

endmodule

// File: tb/tb_axi_err_slave.sv
// Random and directed traffic against a transaction-level model of the
// error slave; checks every response field each cycle.
module tb_axi_err_slave;
  import axi_conf::*;

  logic  clk;
  logic  rst;
  req_t  req;
  resp_t rsp;

  int checks = 0;
  int errors = 0;

  // model: write side open / B owed, read side beats remaining
  bit       w_open;
  bit       b_pend;
  bit [7:0] b_id_m;
  int       r_left;
  bit [7:0] r_id_m;
  int       w_beats;
  int       r_beats;

  axi_err_slave dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi_req_i  (req),
    .axi_resp_o (rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    w_open = 0;
    b_pend = 0;
    b_id_m = '0;
    r_left = 0;
    r_id_m = '0;
  endtask

  task automatic check_outputs();
    chk("aw_ready", rsp.aw_ready, !w_open && !b_pend);
    chk("w_ready", rsp.w_ready, w_open);
    chk("b_valid", rsp.b_valid, b_pend);
    chk("ar_ready", rsp.ar_ready, r_left == 0);
    chk("r_valid", rsp.r_valid, r_left > 0);
    if (b_pend) begin
      chk("b_id", rsp.b.id, b_id_m);
      chk("b_resp", rsp.b.resp, 2'b10);
      chk("b_user", rsp.b.user, 0);
    end
    if (r_left > 0) begin
      chk("r_id", rsp.r.id, r_id_m);
      chk("r_data", rsp.r.data, 64'hDEAD_BEEF_DEAD_BEEF);
      chk("r_resp", rsp.r.resp, 2'b10);
      chk("r_last", rsp.r.last, r_left == 1);
      chk("r_user", rsp.r.user, 0);
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    check_outputs();
    aw_hs = req.aw_valid && !w_open && !b_pend;
    w_hs  = req.w_valid && w_open;
    b_hs  = req.b_ready && b_pend;
    ar_hs = req.ar_valid && r_left == 0;
    r_hs  = req.r_ready && r_left > 0;
    @(posedge clk);
    if (b_hs) b_pend = 0;
    if (w_hs) begin
      w_beats++;
      if (req.w.last) begin
        w_open = 0;
        b_pend = 1;
      end
    end
    if (aw_hs) begin
      w_open = 1;
      b_id_m = req.aw.id;
    end
    if (r_hs) begin
      r_left--;
      r_beats++;
    end
    if (ar_hs) begin
      r_left = int'(req.ar.len) + 1;
      r_id_m = req.ar.id;
    end
    @(negedge clk);
  endtask

  task automatic randomize_inputs(input int len_mode);
    req.aw       = $urandom;
    req.aw.id    = 8'($urandom);
    req.aw_valid = ($urandom_range(0, 3) == 0);
    req.w.data   = {$urandom, $urandom};
    req.w.strb   = 8'($urandom);
    req.w.last   = ($urandom_range(0, 3) == 0);
    req.w_valid  = ($urandom_range(0, 1) == 0);
    req.b_ready  = ($urandom_range(0, 2) != 0);
    req.ar       = $urandom;
    req.ar.id    = 8'($urandom);
    if (len_mode == 0)
      req.ar.len = 8'($urandom_range(0, 7));
    else if ($urandom_range(0, 15) == 0)
      req.ar.len = 8'd255;
    else
      req.ar.len = 8'($urandom_range(0, 15));
    req.ar_valid = ($urandom_range(0, 3) == 0);
    req.r_ready  = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    req = '0;
    rst = 1'b1;
    model_reset();
    w_beats = 0;
    r_beats = 0;
    #2;
    check_outputs();
    chk("rst_cnt_last", rsp.r.last, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single write: id 5A, four beats
    req.aw_valid = 1;
    req.aw.id    = 8'h5A;
    req.aw.len   = 8'd3;
    req.b_ready  = 1;
    step();
    req.aw_valid = 0;
    req.w_valid  = 1;
    w_beats      = 0;
    for (int i = 0; i < 4; i++) begin
      req.w.last = (i == 3);
      step();
    end
    req.w_valid = 0;
    chk("w_beats", w_beats, 4);
    chk("b_after_last", rsp.b_valid, 1);
    step();

    // concurrent AW and AR, 256-beat read
    req.aw_valid = 1;
    req.aw.id    = 8'h33;
    req.ar_valid = 1;
    req.ar.id    = 8'h11;
    req.ar.len   = 8'd255;
    req.r_ready  = 1;
    chk("aw_rdy_same", rsp.aw_ready, 1);
    chk("ar_rdy_same", rsp.ar_ready, 1);
    step();
    req.aw_valid = 0;
    req.ar_valid = 0;
    r_beats      = 0;
    req.w_valid  = 1;
    req.w.last   = 1;
    for (int i = 0; i < 256; i++) step();
    chk("r_beats_256", r_beats, 256);
    chk("ar_rdy_after", rsp.ar_ready, 1);

    // early W: valid three cycles before AW
    req.w_valid = 1;
    req.w.last  = 0;
    w_beats     = 0;
    for (int i = 0; i < 3; i++) step();
    chk("early_w_none", w_beats, 0);
    req.aw_valid = 1;
    req.aw.id    = 8'hC3;
    step();
    req.aw_valid = 0;
    req.w.last   = 1;
    step();
    chk("early_w_one", w_beats, 1);
    req.w_valid = 0;
    step();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs(i < 1000 ? 0 : 1);
      step();
    end

    // reset during beat 4 of a len=7 read
    req = '0;
    for (int i = 0; i < 300; i++) begin
      req.b_ready = 1;
      req.r_ready = 1;
      req.w_valid = 1;
      req.w.last  = 1;
      step();
    end
    req.ar_valid = 1;
    req.ar.id    = 8'h7E;
    req.ar.len   = 8'd7;
    req.r_ready  = 1;
    step();
    req.ar_valid = 0;
    for (int i = 0; i < 3; i++) step();
    chk("beat4_valid", rsp.r_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_r_valid", rsp.r_valid, 0);
    chk("rst_ar_ready", rsp.ar_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    step();
    req.ar_valid = 1;
    req.ar.id    = 8'h42;
    req.ar.len   = 8'd0;
    req.r_ready  = 1;
    step();
    req.ar_valid = 0;
    chk("len0_last", rsp.r.last, 1);
    r_beats = 0;
    for (int i = 0; i < 3; i++) step();
    chk("len0_beats", r_beats, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_err_slave.md
# axi_err_slave

Terminating AXI slave on the pulp-platform `axi_conf::req_t`/`axi_conf::resp_t` pair, placed directly downstream of the AXI slave connector (or of a PMP deny path). It accepts every write and read transaction and completes it protocol-correctly with an error response:

- Write data is absorbed and discarded, and one B beat carries `RESP`.
- Reads return exactly `len+1` R beats carrying `RDATA` and `RESP`, with `last` on the final beat.

Read and write sides are independent, each with one outstanding transaction.

## Interface
- `RESP`, default `2'b10` (SLVERR): response code driven on `b.resp` and `r.resp`. Legal values are `2'b10` and `2'b11`.
- `RDATA`, default `64'hDEAD_BEEF_DEAD_BEEF`: read data pattern, truncated or zero-extended to `axi_conf::DATA_WIDTH`.
- `clk_i`, input, 1: clock. Everything is on the rising edge.
- `rst_i`, input, 1: reset, asynchronous and active-high.
- `axi_req_i`, input, `axi_conf::req_t`: request from the upstream connector.
- `axi_resp_o`, output, `axi_conf::resp_t`: response to the upstream connector.

## Operation
- Write FSM states: `W_IDLE`, `W_DATA`, `W_RESP`.
  - `W_IDLE`: `aw_ready=1`. On `aw_valid&&aw_ready`, latch `aw.id` and go to `W_DATA`.
  - `W_DATA`: `w_ready=1`. Every W beat is discarded. A handshake with `w.last=1` moves the FSM to `W_RESP`.
    - `awlen` is ignored; only `w.last` terminates the burst.
    - W beats presented before AW are not accepted (`w_ready=0` outside `W_DATA`). This is legal slave behaviour.
  - `W_RESP`: `b_valid=1`, `b.id`=latched id, `b.resp=RESP`, `b.user=0`. On `b_ready`, return to `W_IDLE`.
- Read FSM states: `R_IDLE`, `R_DATA`.
  - `R_IDLE`: `ar_ready=1`. On handshake, latch `ar.id` and load the 8-bit beat counter with `ar.len`, then go to `R_DATA`.
  - `R_DATA`: `r_valid=1`, `r.id`=latched id, `r.data=RDATA`, `r.resp=RESP`, `r.user=0`, `r.last=(cnt==0)`.
    - Each `r_ready` handshake decrements `cnt`.
    - The handshake with `last=1` returns the FSM to `R_IDLE`.
- Burst type, size, cache, prot, qos, region, lock and user are ignored. ATOPs are not supported; the struct has no `atop` field.
- Read and write FSMs never interact. Simultaneous AW and AR are both accepted in the same cycle.

## Timing
- All readies and valids decode from registered state only. There is no combinational path from any request field to any response field.
- Reset values (`rst_i` high, asynchronous):
  - Both FSMs go to IDLE, so `aw_ready=1`, `ar_ready=1`.
  - `w_ready=0`, `b_valid=0`, `r_valid=0`.
  - `b.id`/`r.id` registers are 0 and `cnt` is 0.
- Write latency:
  - AW handshake at cycle N gives `w_ready=1` from N+1.
  - `w.last` handshake at cycle M gives `b_valid=1` at M+1.
  - B handshake at cycle K gives `aw_ready=1` at K+1.
- Read latency: AR handshake at cycle N gives the first R beat valid at N+1. With `r_ready` held high, the beats occupy consecutive cycles N+1 … N+1+len.
- AXI stability: while `b_valid`/`r_valid` is high and ready is low, all B/R fields hold stable. `r.last` changes only after a handshake.
- Reset asserted mid-burst: the outstanding transaction is dropped and valids fall asynchronously. After release, both sides are in IDLE with no residual beats.
- `len=255`: 256 beats, and the counter does not wrap before `last`.

## Structure
- The `axi_conf` package holds `req_t`, `resp_t`, `ID_WIDTH` and `DATA_WIDTH`.
  - Add the response code constants `RESP_OKAY`, `RESP_EXOKAY`, `RESP_SLVERR` and `RESP_DECERR` to `axi_conf` so that `RESP` defaults to `axi_conf::RESP_SLVERR`.
- Single module with two independent FSMs and no sub-module. State enums are local to the module.

## Test plan
- Single write: AW id=`8'h5A`, len=3, then 4 W beats with `last` on beat 4 and `b_ready=1` → exactly 4 W handshakes, one B with id `8'h5A`, resp `2'b10`, `b_valid` one cycle after the last W handshake.
- Read burst: AR id=`8'h11`, len=7, `r_ready=1` → 8 consecutive R beats with id `8'h11`, data=`RDATA`, resp `2'b10`, `last` only on beat 8. `ar_ready` is low during the beats and high the cycle after the last beat.
- Backpressure: AR len=2 with `r_ready` toggling 1,0,0,1,… and `b_ready` held low for 5 cycles → R/B fields stable while stalled, exactly 3 R beats, B completes once `b_ready=1`.
- Concurrency: AW and AR issued in the same cycle, read len=255 → both accepted that cycle, write completes independently, 256 R beats with no early `last`.
- Early W: W beats valid 3 cycles before AW → `w_ready=0` until the cycle after the AW handshake, and no beats are lost.
- Reset mid-burst: `rst_i` pulsed during beat 4 of a len=7 read → `r_valid` falls immediately. After release `ar_ready=1`, and a new len=0 read returns one beat with `last=1`.
